// File: rtl/pu_rendezvous_barrier.sv
// Rendezvous barrier for a group of microcode control units.
// Collects per-unit arrive levels for the latched participant set. Once all
// participants have arrived it emits one registered release pulse. It also
// counts completed barriers and traps units that are too slow to arrive.
module pu_rendezvous_barrier #(
  parameter int N_UNITS     = 4,
  parameter int CNT_WIDTH   = 16,
  parameter int TIMEOUT     = 1024,
  parameter int TIMER_WIDTH = $clog2(TIMEOUT + 2)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic [N_UNITS-1:0]   participant_mask,
  input  logic [N_UNITS-1:0]   arrive,
  output logic                 rendezvous,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic                 timeout_err,
  output logic [N_UNITS-1:0]   missing
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    ERROR   = 2'd2
  } state_t;

  localparam bit                     TO_EN  = (TIMEOUT > 0);
  localparam logic [TIMER_WIDTH-1:0] TO_VAL = TIMER_WIDTH'(TIMEOUT);

  state_t                 state, state_n;
  logic [N_UNITS-1:0]     mask_q, mask_n;
  logic [N_UNITS-1:0]     arrived, arrived_n;
  logic [TIMER_WIDTH-1:0] timer, timer_n, timer_inc;
  logic [CNT_WIDTH-1:0]   cnt_n;
  logic [N_UNITS-1:0]     missing_n;
  logic                   rdv_n;
  logic [N_UNITS-1:0]     eff, arr_acc;
  logic                   complete, partial;

  // Next-state and next-register values; outputs come only from registers.
  always_comb begin
    state_n   = state;
    mask_n    = mask_q;
    arrived_n = arrived;
    timer_n   = timer;
    cnt_n     = cycle_count;
    missing_n = missing;
    rdv_n     = 1'b0;
    // A unit still showing arrive during the release cycle is not re-counted.
    eff       = rendezvous ? '0 : (arrive & mask_q);
    arr_acc   = arrived | eff;
    complete  = (arr_acc == mask_q);
    partial   = (arr_acc != '0) && !complete;
    timer_inc = timer + TIMER_WIDTH'(1);

    case (state)
      IDLE, ERROR: begin
        // Stop is a no-op here; only a start with a non-empty mask is accepted.
        if (start && (participant_mask != '0)) begin
          state_n   = COLLECT;
          mask_n    = participant_mask;
          arrived_n = '0;
          timer_n   = '0;
          cnt_n     = '0;
          missing_n = '0;
        end
      end
      COLLECT: begin
        if (complete) begin
          // Completion wins over both stop and timeout.
          rdv_n     = 1'b1;
          arrived_n = '0;
          timer_n   = '0;
          cnt_n     = cycle_count + CNT_WIDTH'(1);
          if (stop) state_n = IDLE;
        end else if (stop) begin
          state_n   = IDLE;
          arrived_n = '0;
          timer_n   = '0;
        end else if (TO_EN && partial) begin
          arrived_n = arr_acc;
          if (timer_inc == TO_VAL) begin
            state_n   = ERROR;
            missing_n = mask_q & ~arr_acc;
          end else begin
            timer_n = timer_inc;
          end
        end else begin
          arrived_n = arr_acc;
          timer_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mask_q      <= '0;
      arrived     <= '0;
      timer       <= '0;
      cycle_count <= '0;
      missing     <= '0;
      rendezvous  <= 1'b0;
    end else begin
      state       <= state_n;
      mask_q      <= mask_n;
      arrived     <= arrived_n;
      timer       <= timer_n;
      cycle_count <= cnt_n;
      missing     <= missing_n;
      rendezvous  <= rdv_n;
    end
  end

  assign busy        = (state == COLLECT);
  assign timeout_err = (state == ERROR);

endmodule

// File: tb/tb_pu_rendezvous_barrier.sv
// Scoreboard bench: stimulus pushes the expected release/error events, and a
// monitor pops and compares them whenever a DUT presents one. Two instances
// share stimulus; the second has a 2-bit counter so the wrap can be observed.
module tb_pu_rendezvous_barrier;

  logic       clk = 1'b0;
  logic       rst, start, stop;
  logic [3:0] pmask, arrive;

  logic        rdv_a, busy_a, err_a;
  logic [15:0] cnt_a;
  logic [3:0]  miss_a;
  logic        rdv_b, busy_b, err_b;
  logic [1:0]  cnt_b;
  logic [3:0]  miss_b;

  pu_rendezvous_barrier #(.N_UNITS(4), .CNT_WIDTH(16), .TIMEOUT(8)) dut_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .participant_mask(pmask), .arrive(arrive),
    .rendezvous(rdv_a), .busy(busy_a), .cycle_count(cnt_a),
    .timeout_err(err_a), .missing(miss_a)
  );

  pu_rendezvous_barrier #(.N_UNITS(4), .CNT_WIDTH(2), .TIMEOUT(8)) dut_b (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .participant_mask(pmask), .arrive(arrive),
    .rendezvous(rdv_b), .busy(busy_b), .cycle_count(cnt_b),
    .timeout_err(err_b), .missing(miss_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    int         cyc;
    int         cnt;
    logic [3:0] miss;
  } exp_t;

  exp_t q[$];
  int   vecs = 0;
  int   errs = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected event dc cycles after the current one.
  task automatic push(input bit is_err, input int dc, input int cnt, input logic [3:0] m);
    exp_t e;
    e.is_err = is_err;
    e.cyc    = cyc + dc;
    e.cnt    = cnt;
    e.miss   = m;
    q.push_back(e);
  endtask

  task automatic chk_b_state(input string nm, input logic busy_e, input logic err_e);
    chk({nm, "_busy_a"}, busy_a, busy_e);
    chk({nm, "_busy_b"}, busy_b, busy_e);
    chk({nm, "_err_a"}, err_a, err_e);
    chk({nm, "_err_b"}, err_b, err_e);
  endtask

  // Monitor: every release pulse cycle or error entry must match the scoreboard.
  logic err_d = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rdv_a === 1'b1 || (err_a === 1'b1 && err_d !== 1'b1)) begin
      if (q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_event: rdv=%0b err=%0b at cycle %0d, none expected", rdv_a, err_a, cyc);
      end else begin
        e = q.pop_front();
        chk("ev_is_err", {31'd0, err_a}, {31'd0, e.is_err});
        chk("ev_cycle", cyc, e.cyc);
        chk("ev_cnt_a", {16'd0, cnt_a}, e.cnt);
        chk("ev_cnt_b", {30'd0, cnt_b}, e.cnt & 3);
        chk("ev_rdv_b", {31'd0, rdv_b}, {31'd0, !e.is_err});
        chk("ev_miss_a", {28'd0, miss_a}, {28'd0, e.miss});
        chk("ev_miss_b", {28'd0, miss_b}, {28'd0, e.miss});
      end
    end
    err_d <= err_a;
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; pmask = '0; arrive = '0;
    repeat (3) tick();
    chk("rst_rdv", rdv_a, 0);
    chk("rst_cnt_a", cnt_a, 0);
    chk("rst_miss_a", miss_a, 0);
    chk_b_state("rst", 1'b0, 1'b0);
    rst = 1'b0;

    // Full mask, one arrival per cycle; later mask changes must not matter.
    pmask = 4'b1111; start = 1'b1; tick(); start = 1'b0; pmask = 4'b0000;
    chk_b_state("t1_start", 1'b1, 1'b0);
    arrive = 4'b0001; tick(); chk("t1_busy0", busy_a, 1);
    arrive = 4'b0011; tick(); chk("t1_busy1", busy_a, 1);
    arrive = 4'b0111; tick(); chk("t1_busy2", busy_a, 1);
    arrive = 4'b1111; push(0, 1, 1, 4'b0000); tick();
    chk("t1_busy_pulse", busy_a, 1);
    arrive = 4'b0000; tick();
    chk("t1_busy_after", busy_a, 1);
    chk("t1_cnt", cnt_a, 1);

    // Stop with partial arrivals: no pulse, count kept.
    arrive = 4'b0011; tick(); tick();
    stop = 1'b1; tick(); stop = 1'b0; arrive = 4'b0000;
    chk_b_state("stop_partial", 1'b0, 1'b0);
    chk("stop_partial_cnt", cnt_a, 1);
    tick();

    // Sparse mask with all arrive bits held high: a pulse every 2nd cycle.
    pmask = 4'b0101; start = 1'b1; tick(); start = 1'b0; pmask = 4'b1111;
    chk("t2_cnt_clear", cnt_a, 0);
    arrive = 4'b1111;
    for (int k = 1; k <= 5; k++) push(0, 2 * k - 1, k, 4'b0000);
    repeat (10) tick();
    arrive = 4'b0000;
    chk("t2_cnt_a", cnt_a, 5);
    chk("t2_cnt_b_wrap", cnt_b, 1);
    stop = 1'b1; tick(); stop = 1'b0;
    chk_b_state("t2_stop", 1'b0, 1'b0);

    // Timeout: only unit 0 arrives.
    pmask = 4'b0011; start = 1'b1; tick(); start = 1'b0;
    arrive = 4'b0001; push(1, 8, 0, 4'b0010);
    repeat (8) tick();
    chk_b_state("t3_err", 1'b0, 1'b1);
    chk("t3_missing", miss_a, 4'b0010);
    stop = 1'b1; arrive = 4'b0011; tick(); stop = 1'b0; tick(); tick();
    chk_b_state("t3_err_held", 1'b0, 1'b1);
    chk("t3_missing_held", miss_a, 4'b0010);
    arrive = 4'b0000; pmask = 4'b0011; start = 1'b1; tick(); start = 1'b0;
    chk_b_state("t3_restart", 1'b1, 1'b0);
    chk("t3_restart_miss", miss_a, 0);
    chk("t3_restart_cnt", cnt_a, 0);

    // Completion and stop in the same cycle.
    arrive = 4'b0001; tick();
    arrive = 4'b0011; stop = 1'b1; push(0, 1, 1, 4'b0000); tick();
    stop = 1'b0; arrive = 4'b0000;
    chk_b_state("t4_idle", 1'b0, 1'b0);
    chk("t4_cnt", cnt_a, 1);
    tick();

    // Reset mid-collection with three of four units arrived.
    pmask = 4'b1111; start = 1'b1; tick(); start = 1'b0;
    arrive = 4'b0111; tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t5_rdv", rdv_a, 0);
    chk("t5_cnt_a", cnt_a, 0);
    chk("t5_cnt_b", cnt_b, 0);
    chk("t5_miss", miss_a, 0);
    chk_b_state("t5_rst", 1'b0, 1'b0);
    arrive = 4'b1111; tick(); tick();
    chk("t5_idle", busy_a, 0);
    start = 1'b1; push(0, 2, 1, 4'b0000); tick(); start = 1'b0; tick();
    chk("t5_busy", busy_a, 1);
    arrive = 4'b0000; tick();

    // Start with an empty mask is ignored.
    stop = 1'b1; tick(); stop = 1'b0;
    pmask = 4'b0000; start = 1'b1; tick(); start = 1'b0;
    chk_b_state("t6_mask0", 1'b0, 1'b0);
    tick();
    chk("t6_mask0_hold", busy_a, 0);

    repeat (3) tick();
    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
